serial_alu_nbit: RTL and testbench
==================================

// Module: serial_alu_nbit
// PURPOSE
//  Parametrised bit-serial arithmetic/logic unit: add, subtract, unsigned compare, bitwise NAND
//  on two WIDTH-bit operands, one bit per clock, LSB first, reusing one full-adder/compare slice.
//  Successor to the 1-bit combinational gate/adder/subtractor/comparator blocks; start/busy/done
//  handshake toward a controller or testbench sequencer.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      synchronous reset, active-low, sampled on rising clk
//  start  in   1      request; accepted only in IDLE or DONE
//  op     in   2      00 ADD, 01 SUB, 10 CMP, 11 NAND; captured with start
//  a      in   WIDTH  operand A; captured with start
//  b      in   WIDTH  operand B; captured with start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse; results valid from this cycle
//  y      out  WIDTH  result: ADD a+b, SUB/CMP a-b (mod 2^WIDTH), NAND ~(a&b)
//  cout   out  1      ADD: carry out; SUB/CMP: borrow (1 when a<b); NAND: 0
//  gt     out  1      CMP only: a>b unsigned; 0 for other ops
//  eq     out  1      CMP only: a==b; 0 for other ops
//  lt     out  1      CMP only: a<b unsigned; 0 for other ops
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; busy,done,y,cout,gt,eq,lt all 0; bit counter 0.
//  Reset has priority over everything; mid-RUN reset aborts, no done pulse, partial y cleared.
//  FSM IDLE/RUN/DONE:
//   IDLE: start=1 -> RUN; latch a,b,op; cnt<=0; carry<=(op==SUB||op==CMP); eq_acc<=1; gt_acc<=0.
//   RUN: each edge processes bit cnt: SUB/CMP use ~b[cnt] with carry (a+~b+1);
//        y[cnt]<=sum or NAND bit; carry<=slice carry; cnt<=cnt+1.
//        CMP tracking: if a[cnt]!=b[cnt] then gt_acc<=a[cnt]; eq_acc<=eq_acc&(a[cnt]==b[cnt]).
//        At edge processing bit WIDTH-1 -> DONE; final flags loaded same edge.
//   DONE: done=1 for exactly this cycle; start=1 -> RUN (back-to-back, new operands latched);
//         else -> IDLE.
//  Latency: start sampled at edge E0 -> done high in cycle after edge E0+WIDTH (WIDTH+1 edges).
//  Throughput: back-to-back one op per WIDTH+1 cycles.
//  busy high exactly WIDTH cycles per op; start while busy ignored, operand/op changes during RUN
//  have no effect (latched copies only).
//  y, cout, gt, eq, lt hold their values from done until the next accepted start.
//  cout: ADD = final carry; SUB/CMP = ~final carry (borrow); NAND = 0.
//  Flags: CMP: gt=gt_acc, eq=eq_acc, lt=~gt_acc&~eq_acc; exactly one of gt/eq/lt high. Non-CMP: all 0.
//  op=11 never drives carry chain; cout=0.
//  Counter width $clog2(WIDTH); no wrap beyond WIDTH-1 (terminates at WIDTH-1).
//  Outputs registered; no combinational path from inputs to outputs.
// TESTING
//  ADD a=8'hFF b=8'h01, start 1 cycle -> busy 8 cycles; done 9 edges after start; y=8'h00 cout=1.
//  SUB a=8'h05 b=8'h07 -> y=8'hFE cout=1; then SUB a=8'h07 b=8'h05 -> y=8'h02 cout=0; flags all 0.
//  CMP (A5,A5) -> eq=1 gt=0 lt=0 y=00; (80,7F) -> gt=1 y=01; (00,FF) -> lt=1 cout=1.
//  NAND a=8'hF0 b=8'hCC -> y=8'h3F cout=0; start re-pulsed and a,b changed mid-RUN -> result unchanged,
//   single done.
//  Back-to-back: start held high -> done pulses every 9 cycles, busy low only in DONE cycles,
//   each result correct for its latched operands.
//  rst_n=0 at RUN bit 3 -> next cycle busy=0 done=0 y=0 flags=0; no done pulse until new start;
//   WIDTH=4 and 16 sweeps pass.

Source files
------------

// File: rtl/serial_alu_nbit.sv
// Bit-serial ALU: ADD, SUB, unsigned CMP and NAND on WIDTH-bit operands,
// one bit per clock, LSB first, through a single full-adder/compare slice.
module serial_alu_nbit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_CMP  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [1:0]       op_r;
   logic             carry_r;
   logic             eq_acc_r;
   logic             gt_acc_r;
   logic [WIDTH-1:0] y_r;
   logic             cout_r;
   logic             gt_r;
   logic             eq_r;
   logic             lt_r;
   logic             busy_r;
   logic             done_r;

   logic             is_sub_s;
   logic             is_cmp_s;
   logic             a_bit_s;
   logic             b_bit_s;
   logic             b_eff_s;
   logic             sum_s;
   logic             cy_s;
   logic             nand_s;
   logic             gt_nxt_s;
   logic             eq_nxt_s;
   logic             cout_nxt_s;

   // Shared bit slice: full adder on the current bit (B inverted for SUB/CMP) plus compare tracking.
   always_comb begin
      is_sub_s   = (op_r == OP_SUB) || (op_r == OP_CMP);
      is_cmp_s   = (op_r == OP_CMP);
      a_bit_s    = a_r[cnt_r];
      b_bit_s    = b_r[cnt_r];
      b_eff_s    = b_bit_s ^ is_sub_s;
      sum_s      = a_bit_s ^ b_eff_s ^ carry_r;
      cy_s       = (a_bit_s & b_eff_s) | (carry_r & (a_bit_s ^ b_eff_s));
      nand_s     = ~(a_bit_s & b_bit_s);
      gt_nxt_s   = (a_bit_s != b_bit_s) ? a_bit_s : gt_acc_r;
      eq_nxt_s   = eq_acc_r & (a_bit_s == b_bit_s);
      cout_nxt_s = 1'b0;
      case (op_r)
         OP_ADD:  cout_nxt_s = cy_s;
         OP_SUB:  cout_nxt_s = ~cy_s;
         OP_CMP:  cout_nxt_s = ~cy_s;
         OP_NAND: cout_nxt_s = 1'b0;
         default: cout_nxt_s = 1'b0;
      endcase
   end

   // Control FSM with operand capture, serial result build-up and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= 2'b00;
         carry_r  <= 1'b0;
         eq_acc_r <= 1'b0;
         gt_acc_r <= 1'b0;
         y_r      <= '0;
         cout_r   <= 1'b0;
         gt_r     <= 1'b0;
         eq_r     <= 1'b0;
         lt_r     <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r  <= ST_RUN;
                  a_r      <= a;
                  b_r      <= b;
                  op_r     <= op;
                  cnt_r    <= '0;
                  carry_r  <= (op == OP_SUB) || (op == OP_CMP);
                  eq_acc_r <= 1'b1;
                  gt_acc_r <= 1'b0;
                  y_r      <= '0;
                  cout_r   <= 1'b0;
                  gt_r     <= 1'b0;
                  eq_r     <= 1'b0;
                  lt_r     <= 1'b0;
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               y_r[cnt_r] <= (op_r == OP_NAND) ? nand_s : sum_s;
               carry_r    <= (op_r == OP_NAND) ? 1'b0 : cy_s;
               gt_acc_r   <= gt_nxt_s;
               eq_acc_r   <= eq_nxt_s;
               if (cnt_r == LAST_BIT) begin
                  // Counter parks on the last bit; flags come from the next-state accumulators.
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  cout_r  <= cout_nxt_s;
                  gt_r    <= is_cmp_s & gt_nxt_s;
                  eq_r    <= is_cmp_s & eq_nxt_s;
                  lt_r    <= is_cmp_s & ~gt_nxt_s & ~eq_nxt_s;
               end else begin
                  cnt_r   <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign y    = y_r;
   assign cout = cout_r;
   assign gt   = gt_r;
   assign eq   = eq_r;
   assign lt   = lt_r;

endmodule

// File: tb/tb_serial_alu_nbit.sv
// Directed bench for serial_alu_nbit: WIDTH=8 main instance plus WIDTH=4 and WIDTH=16 sweeps.
module tb_serial_alu_nbit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [7:0]  a, b;
   logic        busy, done, cout, gt, eq, lt;
   logic [7:0]  y;

   logic [3:0]  a4, b4, y4;
   logic        busy4, done4, cout4, gt4, eq4, lt4;
   logic [15:0] a16, b16, y16;
   logic        busy16, done16, cout16, gt16, eq16, lt16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_alu_nbit #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .y(y), .cout(cout), .gt(gt), .eq(eq), .lt(lt));

   serial_alu_nbit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .y(y4), .cout(cout4), .gt(gt4), .eq(eq4), .lt(lt4));

   serial_alu_nbit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .y(y16), .cout(cout16), .gt(gt16), .eq(eq16), .lt(lt16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation on the WIDTH=8 instance: latency, busy length, results, single done, hold.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] ey, input logic ec,
                         input logic [2:0] eflags);
      int bc, lat;
      logic seen;
      @(negedge clk);
      op = o; a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bc = 0; lat = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) bc++;
         lat++;
         @(negedge clk);
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'd8);
      chk({tag, " busy_cycles"}, 32'(bc), 32'd8);
      chk({tag, " y"}, 32'(y), 32'(ey));
      chk({tag, " cout"}, 32'(cout), 32'(ec));
      chk({tag, " flags"}, 32'({gt, eq, lt}), 32'(eflags));
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " y_hold"}, 32'(y), 32'(ey));
   endtask

   // Same operation on the WIDTH=4 and WIDTH=16 instances in parallel.
   task automatic sweep(input string tag, input logic [1:0] o,
                        input logic [3:0] av4, input logic [3:0] bv4, input logic [3:0] ey4,
                        input logic ec4, input logic [2:0] ef4,
                        input logic [15:0] av16, input logic [15:0] bv16, input logic [15:0] ey16,
                        input logic ec16, input logic [2:0] ef16);
      int l4, l16;
      @(negedge clk);
      op = o; a4 = av4; b4 = bv4; a16 = av16; b16 = bv16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l4 = -1; l16 = -1;
      for (int i = 0; i < 24; i++) begin
         if (done4 && l4 < 0) l4 = i;
         if (done16 && l16 < 0) l16 = i;
         @(negedge clk);
      end
      chk({tag, " w4 latency"}, 32'(l4), 32'd4);
      chk({tag, " w4 y"}, 32'(y4), 32'(ey4));
      chk({tag, " w4 cout"}, 32'(cout4), 32'(ec4));
      chk({tag, " w4 flags"}, 32'({gt4, eq4, lt4}), 32'(ef4));
      chk({tag, " w16 latency"}, 32'(l16), 32'd16);
      chk({tag, " w16 y"}, 32'(y16), 32'(ey16));
      chk({tag, " w16 cout"}, 32'(cout16), 32'(ec16));
      chk({tag, " w16 flags"}, 32'({gt16, eq16, lt16}), 32'(ef16));
      chk({tag, " idle busy"}, 32'({busy4, busy16}), 32'd0);
   endtask

   logic [1:0] bb_op [4];
   logic [7:0] bb_a [4], bb_b [4], bb_y [4];
   logic       bb_c [4];
   logic [2:0] bb_f [4];

   initial begin
      int gap, nb, dcnt;
      logic seen;
      logic [7:0] ycap;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
      a4 = 4'h0; b4 = 4'h0; a16 = 16'h0000; b16 = 16'h0000;
      repeat (2) @(negedge clk);
      chk("reset outputs", 32'({busy, done, y, cout, gt, eq, lt}), 32'd0);
      rst_n = 1'b1;

      // flags are {gt, eq, lt}
      run_op("add_ff_01",  2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 3'b000);
      run_op("sub_05_07",  2'b01, 8'h05, 8'h07, 8'hFE, 1'b1, 3'b000);
      run_op("sub_07_05",  2'b01, 8'h07, 8'h05, 8'h02, 1'b0, 3'b000);
      run_op("cmp_a5_a5",  2'b10, 8'hA5, 8'hA5, 8'h00, 1'b0, 3'b010);
      run_op("cmp_80_7f",  2'b10, 8'h80, 8'h7F, 8'h01, 1'b0, 3'b100);
      run_op("cmp_00_ff",  2'b10, 8'h00, 8'hFF, 8'h01, 1'b1, 3'b001);
      run_op("add_after_cmp", 2'b00, 8'h80, 8'h7F, 8'hFF, 1'b0, 3'b000);
      run_op("nand_f0_cc", 2'b11, 8'hF0, 8'hCC, 8'h3F, 1'b0, 3'b000);

      // start re-pulsed and operands changed mid-RUN must not disturb the latched operation
      @(negedge clk);
      op = 2'b11; a = 8'hF0; b = 8'hCC; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op = 2'b00; a = 8'h00; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'h11; b = 8'h22;
      dcnt = 0; ycap = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (done) begin
            dcnt++;
            ycap = y;
         end
         @(negedge clk);
      end
      chk("midrun done_count", 32'(dcnt), 32'd1);
      chk("midrun y", 32'(ycap), 32'h3F);
      chk("midrun cout", 32'(cout), 32'd0);

      // back-to-back with start held high
      bb_op[0] = 2'b00; bb_a[0] = 8'h12; bb_b[0] = 8'h34; bb_y[0] = 8'h46; bb_c[0] = 1'b0; bb_f[0] = 3'b000;
      bb_op[1] = 2'b01; bb_a[1] = 8'h10; bb_b[1] = 8'h20; bb_y[1] = 8'hF0; bb_c[1] = 1'b1; bb_f[1] = 3'b000;
      bb_op[2] = 2'b10; bb_a[2] = 8'h3C; bb_b[2] = 8'h3D; bb_y[2] = 8'hFF; bb_c[2] = 1'b1; bb_f[2] = 3'b001;
      bb_op[3] = 2'b11; bb_a[3] = 8'hFF; bb_b[3] = 8'hFF; bb_y[3] = 8'h00; bb_c[3] = 1'b0; bb_f[3] = 3'b000;
      @(negedge clk);
      op = bb_op[0]; a = bb_a[0]; b = bb_b[0]; start = 1'b1;
      nb = 0;
      for (int k = 0; k < 4; k++) begin
         gap = 0; seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gap++;
            if (done) begin
               seen = 1'b1;
               break;
            end
            if (!busy) nb++;
         end
         chk($sformatf("b2b%0d done_seen", k), 32'(seen), 32'd1);
         chk($sformatf("b2b%0d gap", k), 32'(gap), 32'd9);
         chk($sformatf("b2b%0d y", k), 32'(y), 32'(bb_y[k]));
         chk($sformatf("b2b%0d cout", k), 32'(cout), 32'(bb_c[k]));
         chk($sformatf("b2b%0d flags", k), 32'({gt, eq, lt}), 32'(bb_f[k]));
         chk($sformatf("b2b%0d busy_in_done", k), 32'(busy), 32'd0);
         if (k < 3) begin
            op = bb_op[k+1]; a = bb_a[k+1]; b = bb_b[k+1];
         end else begin
            start = 1'b0;
         end
      end
      chk("b2b busy_low_outside_done", 32'(nb), 32'd0);
      repeat (2) @(negedge clk);

      // reset asserted for the edge that would process bit 3
      op = 2'b00; a = 8'h0F; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst outputs", 32'({busy, done, y, cout, gt, eq, lt}), 32'd0);
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("midrst no_done", 32'(dcnt), 32'd0);
      chk("midrst idle", 32'({busy, y}), 32'd0);

      sweep("sw_add", 2'b00, 4'h9, 4'h8, 4'h1, 1'b1, 3'b000,
            16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3'b000);
      sweep("sw_cmp", 2'b10, 4'h3, 4'hC, 4'h7, 1'b1, 3'b001,
            16'h1234, 16'h1233, 16'h0001, 1'b0, 3'b100);
      sweep("sw_sub", 2'b01, 4'h5, 4'h5, 4'h0, 1'b0, 3'b000,
            16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
